// File: rtl/crypt_sequencer_pkg.sv
// Shared state encoding, framing constants and helpers for the crypt_sequencer RSA byte-stream
// controller.
package crypt_sequencer_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned PT_BYTES   = 3;
    localparam int unsigned HDR_BYTES  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StCollect,
        StExp,
        StExpWait,
        StSend,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        PkHold,
        PkClear,
        PkShiftIn,
        PkShiftOut,
        PkLoad
    } pk_op_e;

    // A short plaintext word (closed early by eot) keeps its bytes MSB-aligned in [23:0].
    function automatic logic [31:0] pad_plaintext(input logic [31:0] word,
                                                  input logic [2:0]  nbytes);
        case (nbytes)
            3'd1:    pad_plaintext = word << 16;
            3'd2:    pad_plaintext = word << 8;
            default: pad_plaintext = word;
        endcase
    endfunction

endpackage

// File: rtl/crypt_sequencer_byte_packer.sv
// 32-bit byte shift register with a byte counter, used both to assemble incoming words and to
// serialise results MSB-first.
module crypt_sequencer_byte_packer
    import crypt_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pk_op_e      op,
    input  logic [7:0]  din,
    input  logic [31:0] load_word,
    input  logic [2:0]  len,
    output logic [31:0] word,
    output logic [2:0]  count,
    output logic        full,
    output logic [7:0]  byte_out
);

    logic [31:0] word_q;
    logic [2:0]  count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            case (op)
                PkClear: begin
                    word_q  <= '0;
                    count_q <= '0;
                end
                PkShiftIn: begin
                    word_q  <= {word_q[23:0], din};
                    count_q <= count_q + 3'd1;
                end
                PkShiftOut: begin
                    word_q  <= {word_q[23:0], 8'h00};
                    count_q <= count_q + 3'd1;
                end
                PkLoad: begin
                    word_q  <= load_word;
                    count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign word     = word_q;
    assign count    = count_q;
    assign full     = (count_q == len);
    assign byte_out = word_q[31:24];

endmodule

// File: rtl/crypt_sequencer.sv
// RSA byte-stream sequencer: frames UART bytes into words, drives an external modexp engine and
// serialises each result back out to the UART transmitter.
module crypt_sequencer
    import crypt_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] n_key,
    input  logic [31:0] e_key,
    input  logic [31:0] d_key,
    input  logic        ready_in,
    input  logic [7:0]  data_in,
    input  logic        eot_in,
    input  logic        tx_done_tick,
    input  logic        exp_done,
    input  logic [31:0] exp_result,
    output logic        clear_rx_flag,
    output logic        start_out,
    output logic [7:0]  data_out,
    output logic        exp_start,
    output logic [31:0] exp_base,
    output logic [31:0] exp_exp,
    output logic [31:0] exp_mod,
    output logic        busy,
    output logic        err
);

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [31:0] n_q, n_d, key_q, key_d, len_q, len_d, base_q, base_d;
    logic        eot_q, eot_d, tx_wait_q, tx_wait_d;
    logic        clear_q, clear_d, start_out_q, start_out_d;
    logic        exp_start_q, exp_start_d, err_q, err_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        accept, word_finished;

    pk_op_e      pk_op;
    logic [31:0] pk_load, pk_word;
    logic [2:0]  pk_len, pk_count;
    logic        pk_full;
    logic [7:0]  pk_byte;

    crypt_sequencer_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .op        (pk_op),
        .din       (data_in),
        .load_word (pk_load),
        .len       (pk_len),
        .word      (pk_word),
        .count     (pk_count),
        .full      (pk_full),
        .byte_out  (pk_byte)
    );

    always_comb begin
        pk_len = 3'(HDR_BYTES);
        if (state_q == StCollect) pk_len = mode_q ? 3'(PT_BYTES) : 3'(WORD_BYTES);
        if (state_q == StSend)    pk_len = mode_q ? 3'(WORD_BYTES) : 3'(PT_BYTES);
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        n_d           = n_q;
        key_d         = key_q;
        len_d         = len_q;
        base_d        = base_q;
        eot_d         = eot_q;
        tx_wait_d     = tx_wait_q;
        data_out_d    = data_out_q;
        clear_d       = 1'b0;
        start_out_d   = 1'b0;
        exp_start_d   = 1'b0;
        err_d         = 1'b0;
        word_finished = 1'b0;
        pk_op         = PkHold;
        pk_load       = '0;
        // A byte is still pending in the cycle its clear pulse is out, so it must not count twice.
        accept = ready_in && !clear_q && ((state_q == StHdr) || (state_q == StCollect));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode;
                    n_d     = n_key;
                    key_d   = mode ? e_key : d_key;
                    len_d   = '0;
                    eot_d   = 1'b0;
                    pk_op   = PkClear;
                    state_d = mode ? StCollect : StHdr;
                end
            end
            StHdr: begin
                if (pk_full) begin
                    if (pk_word == '0) begin
                        state_d = StDone;
                    end else begin
                        len_d   = pk_word;
                        pk_op   = PkClear;
                        state_d = StCollect;
                    end
                end else if (accept) begin
                    clear_d = 1'b1;
                    pk_op   = PkShiftIn;
                end
            end
            StCollect: begin
                if (pk_full || eot_q) begin
                    state_d = StExp;
                end else if (accept) begin
                    clear_d = 1'b1;
                    pk_op   = PkShiftIn;
                    if (mode_q && eot_in) eot_d = 1'b1;
                end
            end
            StExp: begin
                if (!mode_q && (pk_word >= n_q)) begin
                    err_d         = 1'b1;
                    word_finished = 1'b1;
                end else begin
                    exp_start_d = 1'b1;
                    base_d      = mode_q ? pad_plaintext(pk_word, pk_count) : pk_word;
                    state_d     = StExpWait;
                end
            end
            StExpWait: begin
                if (exp_done) begin
                    pk_op     = PkLoad;
                    pk_load   = mode_q ? exp_result : {exp_result[23:0], 8'h00};
                    tx_wait_d = 1'b0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (!tx_wait_q) begin
                    start_out_d = 1'b1;
                    data_out_d  = pk_byte;
                    pk_op       = PkShiftOut;
                    tx_wait_d   = 1'b1;
                end else if (tx_done_tick) begin
                    tx_wait_d = 1'b0;
                    if (pk_full) word_finished = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Shared end-of-word bookkeeping for both a sent word and a rejected ciphertext.
        if (word_finished) begin
            if (mode_q) begin
                if (eot_q) begin
                    state_d = StDone;
                end else begin
                    pk_op   = PkClear;
                    state_d = StCollect;
                end
            end else begin
                len_d = len_q - 32'd1;
                if (len_q == 32'd1) begin
                    state_d = StDone;
                end else begin
                    pk_op   = PkClear;
                    state_d = StCollect;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            n_q         <= '0;
            key_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            eot_q       <= 1'b0;
            tx_wait_q   <= 1'b0;
            data_out_q  <= '0;
            clear_q     <= 1'b0;
            start_out_q <= 1'b0;
            exp_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            n_q         <= n_d;
            key_q       <= key_d;
            len_q       <= len_d;
            base_q      <= base_d;
            eot_q       <= eot_d;
            tx_wait_q   <= tx_wait_d;
            data_out_q  <= data_out_d;
            clear_q     <= clear_d;
            start_out_q <= start_out_d;
            exp_start_q <= exp_start_d;
            err_q       <= err_d;
        end
    end

    assign clear_rx_flag = clear_q;
    assign start_out     = start_out_q;
    assign data_out      = data_out_q;
    assign exp_start     = exp_start_q;
    assign exp_base      = base_q;
    assign exp_exp       = key_q;
    assign exp_mod       = n_q;
    assign err           = err_q;
    assign busy          = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_crypt_sequencer.sv
// Self-checking bench for crypt_sequencer: UART and modexp-engine models plus a session-level
// scoreboard of expected engine operands, transmitted bytes and error pulses.
module tb_crypt_sequencer;

    localparam logic [31:0] N = 32'd96022049;
    localparam logic [31:0] E = 32'd88637233;
    localparam logic [31:0] D = 32'd39370597;

    logic        clk;
    logic        rst, start, mode, ready_in, eot_in, tx_done_tick, exp_done;
    logic [31:0] n_key, e_key, d_key, exp_result;
    logic [7:0]  data_in;
    logic        clear_rx_flag, start_out, exp_start, busy, err;
    logic [7:0]  data_out;
    logic [31:0] exp_base, exp_exp, exp_mod;

    crypt_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .n_key         (n_key),
        .e_key         (e_key),
        .d_key         (d_key),
        .ready_in      (ready_in),
        .data_in       (data_in),
        .eot_in        (eot_in),
        .tx_done_tick  (tx_done_tick),
        .exp_done      (exp_done),
        .exp_result    (exp_result),
        .clear_rx_flag (clear_rx_flag),
        .start_out     (start_out),
        .data_out      (data_out),
        .exp_start     (exp_start),
        .exp_base      (exp_base),
        .exp_exp       (exp_exp),
        .exp_mod       (exp_mod),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0, tx_cnt = 0, clear_cnt = 0, err_cnt = 0, engdone_cnt = 0;
    int eng_lat = 4;
    int err_pending = 0;
    bit skip_hold = 1'b0;
    logic [31:0] q_base[$], q_exp[$], q_mod[$];
    logic [7:0]  q_tx[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        longint unsigned r, x, mm;
        if (m == 32'd0) return 32'd0;
        mm = {32'h0, m};
        r  = 64'd1 % mm;
        x  = {32'h0, b} % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return 32'(r);
    endfunction

    // Session model: one engine call per word, result bytes as the protocol frames them.
    task automatic expect_word(input logic [31:0] base, input logic [31:0] key,
                               input logic [31:0] n, input logic enc);
        logic [31:0] r;
        q_base.push_back(base);
        q_exp.push_back(key);
        q_mod.push_back(n);
        r = modexp(base, key, n);
        if (enc) q_tx.push_back(r[31:24]);
        q_tx.push_back(r[23:16]);
        q_tx.push_back(r[15:8]);
        q_tx.push_back(r[7:0]);
    endtask

    // Compare process.
    always @(negedge clk) begin
        if (clear_rx_flag) clear_cnt++;
        if (exp_start) begin
            exp_cnt++;
            checks++;
            if (q_base.size() == 0) begin
                errors++;
                $display("FAIL exp_start_unexpected: got base 0x%08h, want no call", exp_base);
            end else begin
                check("exp_base", exp_base, q_base.pop_front());
                check("exp_exp", exp_exp, q_exp.pop_front());
                check("exp_mod", exp_mod, q_mod.pop_front());
            end
        end
        if (start_out) begin
            tx_cnt++;
            checks++;
            if (q_tx.size() == 0) begin
                errors++;
                $display("FAIL start_out_unexpected: got byte 0x%02h, want no byte", data_out);
            end else begin
                check("tx_byte", 32'(data_out), 32'(q_tx.pop_front()));
            end
        end
        if (err) begin
            err_cnt++;
            checks++;
            if (err_pending == 0) begin
                errors++;
                $display("FAIL err_unexpected: got err pulse, want none");
            end else begin
                err_pending--;
            end
        end
    end

    // Modexp engine model.
    initial begin
        logic [31:0] b, e, m;
        exp_done   = 1'b0;
        exp_result = '0;
        forever begin
            @(negedge clk);
            if (exp_start) begin
                b = exp_base;
                e = exp_exp;
                m = exp_mod;
                repeat (eng_lat) @(negedge clk);
                if (!skip_hold) begin
                    check("exp_base_hold", exp_base, b);
                    check("exp_mod_hold", exp_mod, m);
                end
                exp_result = modexp(b, e, m);
                exp_done   = 1'b1;
                engdone_cnt++;
                @(negedge clk);
                exp_done = 1'b0;
            end
        end
    end

    // UART transmitter model.
    initial begin
        logic [7:0] held;
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (start_out) begin
                held = data_out;
                repeat (3) @(negedge clk);
                check("data_out_hold", 32'(data_out), 32'(held));
                tx_done_tick = 1'b1;
                @(negedge clk);
                tx_done_tick = 1'b0;
            end
        end
    end

    // Hold ready_in through the clear cycle so a double accept would be visible.
    task automatic send_byte(input logic [7:0] b, input logic eot);
        bit got;
        got = 1'b0;
        @(negedge clk);
        ready_in = 1'b1;
        data_in  = b;
        eot_in   = eot;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (clear_rx_flag) got = 1'b1;
        end
        check("byte_consumed", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        ready_in = 1'b0;
        eot_in   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b0);
    endtask

    task automatic do_start(input logic m, input string name);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 5000 && busy; c++) @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_tx_dones(input int k, input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < 3000 && seen < k; c++) begin
            @(posedge clk);
            if (tx_done_tick) seen++;
        end
        check({name, "_tx_done_seen"}, seen, k);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_start_out"}, 32'(start_out), 32'd0);
        check({name, "_exp_start"}, 32'(exp_start), 32'd0);
        check({name, "_clear_rx_flag"}, 32'(clear_rx_flag), 32'd0);
        check({name, "_data_out"}, 32'(data_out), 32'd0);
        check({name, "_exp_base"}, exp_base, 32'd0);
        check({name, "_exp_exp"}, exp_exp, 32'd0);
        check({name, "_exp_mod"}, exp_mod, 32'd0);
    endtask

    initial begin
        int tx0, ex0, cl0, er0, ed0, bc;
        rst = 1'b1; start = 1'b0; mode = 1'b0; ready_in = 1'b0; data_in = '0; eot_in = 1'b0;
        n_key = '0; e_key = '0; d_key = '0;

        // Pin the reference modexp with hand-computed values.
        check("model_2_10_1000", modexp(32'd2, 32'd10, 32'd1000), 32'd24);
        check("model_3_5_7", modexp(32'd3, 32'd5, 32'd7), 32'd5);
        check("model_4_13_497", modexp(32'd4, 32'd13, 32'd497), 32'd445);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        n_key = N; e_key = E; d_key = D;

        // Encrypt: a full 3-byte word, a restart attempt while busy, then an eot-closed word.
        tx0 = tx_cnt; ex0 = exp_cnt; cl0 = clear_cnt;
        do_start(1'b1, "enc");
        expect_word(32'h00EBCB83, E, N, 1'b1);
        expect_word(32'h0004FF00, E, N, 1'b1);
        @(negedge clk);
        n_key = 32'd1234; e_key = 32'd7; d_key = 32'd9; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_key = N; e_key = E; d_key = D;
        check("restart_ignored_exp_exp", exp_exp, E);
        send_byte(8'hEB, 1'b0);
        send_byte(8'hCB, 1'b0);
        send_byte(8'h83, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_tx_dones(4, "enc");
        @(negedge clk);
        check("enc_busy_fall", 32'(busy), 32'd0);
        check("enc_exp_calls", exp_cnt - ex0, 2);
        check("enc_tx_bytes", tx_cnt - tx0, 8);
        check("enc_clears", clear_cnt - cl0, 5);

        // Decrypt: two in-range ciphertext words.
        tx0 = tx_cnt; ex0 = exp_cnt; cl0 = clear_cnt;
        do_start(1'b0, "dec");
        expect_word(32'h01234567, D, N, 1'b0);
        expect_word(32'h00ABCDEF, D, N, 1'b0);
        send_word(32'd2);
        send_word(32'h01234567);
        send_word(32'h00ABCDEF);
        wait_idle("dec");
        check("dec_exp_calls", exp_cnt - ex0, 2);
        check("dec_tx_bytes", tx_cnt - tx0, 6);
        check("dec_clears", clear_cnt - cl0, 12);

        // Out-of-range ciphertext is rejected and still consumes one word of the count.
        tx0 = tx_cnt; ex0 = exp_cnt; er0 = err_cnt;
        err_pending = 1;
        do_start(1'b0, "oor");
        expect_word(32'd5, D, N, 1'b0);
        send_word(32'd2);
        send_word(32'hFFFFFFFF);
        send_word(32'd5);
        wait_idle("oor");
        check("oor_err_pulses", err_cnt - er0, 1);
        check("oor_exp_calls", exp_cnt - ex0, 1);
        check("oor_tx_bytes", tx_cnt - tx0, 3);

        // Reset while the engine is busy; its late result must be dropped.
        tx0 = tx_cnt; ex0 = exp_cnt; ed0 = engdone_cnt;
        eng_lat = 30;
        skip_hold = 1'b1;
        do_start(1'b1, "rst");
        expect_word(32'h00112233, E, N, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        for (int c = 0; c < 500 && exp_cnt == ex0; c++) @(negedge clk);
        check("rst_exp_call", exp_cnt - ex0, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        q_tx.delete();
        rst = 1'b0;
        for (int c = 0; c < 200 && engdone_cnt == ed0; c++) @(negedge clk);
        check("rst_late_exp_done", engdone_cnt - ed0, 1);
        repeat (10) @(negedge clk);
        check("rst_idle_busy", 32'(busy), 32'd0);
        check("rst_no_tx", tx_cnt - tx0, 0);
        skip_hold = 1'b0;
        eng_lat = 4;

        // Zero-length decrypt session.
        tx0 = tx_cnt; ex0 = exp_cnt;
        do_start(1'b0, "hdr0");
        send_word(32'd0);
        bc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        check("hdr0_busy_le6", 32'(bc <= 6), 32'd1);
        check("hdr0_idle", 32'(busy), 32'd0);
        check("hdr0_exp_calls", exp_cnt - ex0, 0);
        check("hdr0_tx_bytes", tx_cnt - tx0, 0);

        check("left_tx_expected", q_tx.size(), 0);
        check("left_exp_expected", q_base.size(), 0);
        check("left_err_expected", err_pending, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
